mem_port_arbiter: RTL

- Shares one single-port, synchronous-read data/instruction memory between the fetch stage (IF) and the data-access path (ID/EX → DM).
- Grants at most one access per cycle and drives the memory port.
- Steers the read data back to the owner one cycle later, with a valid strobe.
- Data accesses have priority. A starvation counter forces a fetch grant so that IF always progresses; the core stalls IF whenever it is not granted.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types and defaults for the IF/DM memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int STARVE_W   = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DM   = 2'b10
    } owner_e;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v == {STARVE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Single-port memory arbiter, DM priority with IF anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    owner_e              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                force_if;

    assign force_if = (starve_cnt_q >= STARVE_LIM);

    // Everything combinational is held at zero while rst is low.
    always_comb begin
        if_gnt       = 1'b0;
        dm_gnt       = 1'b0;
        stall_if     = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        owner_d      = OWN_NONE;
        starve_cnt_d = '0;
        if (rst) begin
            dm_gnt   = dm_req & ~(if_req & force_if);
            if_gnt   = if_req & ~dm_gnt;
            stall_if = if_req & ~if_gnt;
            mem_en   = if_gnt | dm_gnt;
            mem_we   = dm_gnt & dm_we;
            if (dm_gnt) begin
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end else if (if_gnt) begin
                mem_addr  = if_addr;
            end
            if (if_gnt) begin
                owner_d = OWN_IF;
            end else if (dm_gnt && !dm_we) begin
                owner_d = OWN_DM;
            end
            if (if_req && !if_gnt) begin
                starve_cnt_d = sat_inc(starve_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Read data is shared; the owner strobe tells each consumer when to take it.
    assign if_rvalid = (owner_q == OWN_IF);
    assign dm_rvalid = (owner_q == OWN_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule
`default_nettype wire
